// File: rtl/hubris_io_pkg.sv
// Shared constants for the multi-channel output IO buffer.
// Overflow-mode encodings, counter widths and the channel-select width helper.
package hubris_io_pkg;

  localparam int OVF_STALL  = 0;
  localparam int OVF_DROP   = 1;
  localparam int DROP_CNT_W = 16;
  localparam int SIZE_W     = 32;

  // A single channel still needs a 1-bit select port.
  function automatic int chan_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_output_fifo.sv
// Single-channel first-word-fall-through FIFO used by io_output_buffer_mc.
// Full/empty decisions come from the registered count, so a pop never frees a slot in the same cycle.
module io_output_fifo
  import hubris_io_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  accept,
  output logic [SIZE_W-1:0]     size
);

  // Plain array so benches can peek at storage hierarchically.
  reg [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  assign full   = (count_reg == CNT_W'(DEPTH));
  assign push   = push_req && !full;
  assign pop    = rd_en && (count_reg != '0);
  assign accept = push;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign size    = {{(SIZE_W - CNT_W){1'b0}}, count_reg};

endmodule

// File: rtl/io_output_buffer_mc.sv
// Multi-channel output IO buffer: write demux into CHANNELS FIFOs with either
// backpressure or drop-newest overflow handling (sticky flag + saturating drop count).
module io_output_buffer_mc
  import hubris_io_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int CHANNELS      = 2,
  parameter int OVERFLOW_MODE = OVF_STALL,
  localparam int CH_W         = chan_sel_w(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [CH_W-1:0]                  wr_chan,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             wr_ready,
  input  logic [CHANNELS-1:0]              rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0]   rd_data,
  output logic [CHANNELS*SIZE_W-1:0]       size_avai,
  output logic [CHANNELS-1:0]              overflow,
  input  logic [CHANNELS-1:0]              clear_overflow,
  output logic [CHANNELS*DROP_CNT_W-1:0]   drop_count
);

  logic [CHANNELS-1:0] full_vec;
  logic [CHANNELS-1:0] accept_vec;
  logic [CHANNELS-1:0] sel_vec;
  logic                sel_full;

  // An out-of-range channel matches nothing, leaving wr_ready high.
  always_comb begin
    sel_full = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_chan == CH_W'(c)) begin
        sel_full = full_vec[c];
      end
    end
  end

  assign wr_ready = (OVERFLOW_MODE == OVF_DROP) ? 1'b1 : !sel_full;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic                  drop;
      logic                  ovf_reg;
      logic [DROP_CNT_W-1:0] drop_cnt_reg;

      assign sel_vec[gi] = wr_en && (wr_chan == CH_W'(gi));

      io_output_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_req (sel_vec[gi] && wr_ready),
        .wr_data  (wr_data),
        .rd_en    (rd_en[gi]),
        .rd_data  (rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .full     (full_vec[gi]),
        .accept   (accept_vec[gi]),
        .size     (size_avai[gi*SIZE_W +: SIZE_W])
      );

      assign drop = (OVERFLOW_MODE == OVF_DROP) && sel_vec[gi] && !accept_vec[gi];

      // A drop coinciding with a clear wins: flag stays set, count restarts at one.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_reg      <= 1'b0;
          drop_cnt_reg <= '0;
        end else if (drop) begin
          ovf_reg <= 1'b1;
          if (clear_overflow[gi]) begin
            drop_cnt_reg <= DROP_CNT_W'(1);
          end else if (drop_cnt_reg != '1) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
          end
        end else if (clear_overflow[gi]) begin
          ovf_reg      <= 1'b0;
          drop_cnt_reg <= '0;
        end
      end

      assign overflow[gi]                            = ovf_reg;
      assign drop_count[gi*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_reg;
    end
  endgenerate

endmodule
